croc_pad_mux: RTL and testbench

//  Configurable pad multiplexer between the pad ring and the SoC. For each of NumPads

---
 rtl/croc_pad_mux.sv | 178 +++++++++++++++++
 tb/tb_croc_pad_mux.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/croc_pad_mux.sv
// Pad mux: per-pad GPIO/alt-function routing, 2-flop input sync, optional debounce.
// Latency: output path combinational from config; pad-to-input 2 cycles (+T when debounced); reg response 1 cycle.
// Backpressure: none; every register request is granted in the cycle it is presented.
module croc_pad_mux #(
    parameter int unsigned NumPads         = 32,
    parameter int unsigned NumAlt          = 2,
    parameter int unsigned DebounceW       = 8,
    parameter int unsigned DebounceDefault = 16,
    parameter logic        AltInIdle       = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        reg_req_i,
    input  logic                        reg_we_i,
    input  logic [7:0]                  reg_addr_i,
    input  logic [31:0]                 reg_wdata_i,
    output logic                        reg_gnt_o,
    output logic                        reg_rvalid_o,
    output logic [31:0]                 reg_rdata_o,
    output logic                        reg_err_o,
    input  logic [NumPads-1:0]          gpio_o_i,
    input  logic [NumPads-1:0]          gpio_oe_i,
    output logic [NumPads-1:0]          gpio_i_o,
    input  logic [NumAlt*NumPads-1:0]   alt_o_i,
    input  logic [NumAlt*NumPads-1:0]   alt_oe_i,
    output logic [NumAlt*NumPads-1:0]   alt_i_o,
    output logic [NumPads-1:0]          pad_c2p_o,
    output logic [NumPads-1:0]          pad_c2p_en_o,
    input  logic [NumPads-1:0]          pad_p2c_i
);
    localparam int unsigned AddrThr  = NumPads;
    localparam int unsigned AddrStat = NumPads + 1;
    localparam int unsigned StatW    = (NumPads < 32) ? NumPads : 32;

    logic [3:0]           sel_q [NumPads];
    logic [NumPads-1:0]   deb_en_q;
    logic [NumPads-1:0]   force_in_q;
    logic [DebounceW-1:0] thr_q;
    logic [DebounceW-1:0] thr_m1;
    logic [DebounceW-1:0] cnt_q [NumPads];
    logic [NumPads-1:0]   sync1_q;
    logic [NumPads-1:0]   sync2_q;
    logic [NumPads-1:0]   filt_q;
    logic [NumPads-1:0]   deb_active;
    logic [NumPads-1:0]   cond;

    logic                 rvalid_q;
    logic                 err_q;
    logic [31:0]          rdata_q;
    logic [31:0]          rd_val;
    logic                 req_err;
    logic                 unused_wdata;

    logic [NumPads-1:0]        c2p;
    logic [NumPads-1:0]        c2p_en;
    logic [NumAlt*NumPads-1:0] alt_in;

    assign unused_wdata = ^reg_wdata_i[31:6];

    // Address decode; writes and errored accesses always return zero data.
    always_comb begin
        rd_val  = '0;
        req_err = 1'b0;
        if (reg_addr_i < 8'(NumPads)) begin
            for (int n = 0; n < NumPads; n++) begin
                if (reg_addr_i == 8'(n)) begin
                    rd_val[5:0] = {force_in_q[n], deb_en_q[n], sel_q[n]};
                end
            end
            if (reg_we_i && (reg_wdata_i[3:0] > 4'(NumAlt))) begin
                req_err = 1'b1;
            end
        end else if (reg_addr_i == 8'(AddrThr)) begin
            rd_val[DebounceW-1:0] = thr_q;
        end else if (reg_addr_i == 8'(AddrStat)) begin
            for (int n = 0; n < StatW; n++) begin
                rd_val[n] = sync2_q[n];
            end
            req_err = reg_we_i;
        end else begin
            req_err = 1'b1;
        end
        if (reg_we_i || req_err) begin
            rd_val = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            thr_q      <= DebounceW'(DebounceDefault);
            deb_en_q   <= '0;
            force_in_q <= '0;
            for (int n = 0; n < NumPads; n++) begin
                sel_q[n] <= '0;
            end
        end else begin
            rvalid_q <= reg_req_i;
            err_q    <= reg_req_i & req_err;
            rdata_q  <= reg_req_i ? rd_val : '0;
            if (reg_req_i && reg_we_i && !req_err) begin
                for (int n = 0; n < NumPads; n++) begin
                    if (reg_addr_i == 8'(n)) begin
                        sel_q[n]      <= reg_wdata_i[3:0];
                        deb_en_q[n]   <= reg_wdata_i[4];
                        force_in_q[n] <= reg_wdata_i[5];
                    end
                end
                if (reg_addr_i == 8'(AddrThr)) begin
                    thr_q <= reg_wdata_i[DebounceW-1:0];
                end
            end
        end
    end

    assign reg_gnt_o    = reg_req_i;
    assign reg_rvalid_o = rvalid_q;
    assign reg_rdata_o  = rdata_q;
    assign reg_err_o    = err_q;

    assign thr_m1     = thr_q - DebounceW'(1);
    assign deb_active = deb_en_q & {NumPads{thr_q != '0}};
    assign cond       = (deb_active & filt_q) | (~deb_active & sync2_q);

    // ">=" rather than "==" so a threshold lowered below a running count still commits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            for (int n = 0; n < NumPads; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            sync1_q <= pad_p2c_i;
            sync2_q <= sync1_q;
            for (int n = 0; n < NumPads; n++) begin
                if (!deb_active[n]) begin
                    filt_q[n] <= sync2_q[n];
                    cnt_q[n]  <= '0;
                end else if (sync2_q[n] == filt_q[n]) begin
                    cnt_q[n] <= '0;
                end else if (cnt_q[n] >= thr_m1) begin
                    filt_q[n] <= sync2_q[n];
                    cnt_q[n]  <= '0;
                end else begin
                    cnt_q[n] <= cnt_q[n] + DebounceW'(1);
                end
            end
        end
    end

    always_comb begin
        c2p    = gpio_o_i;
        c2p_en = gpio_oe_i;
        alt_in = {(NumAlt*NumPads){AltInIdle}};
        for (int n = 0; n < NumPads; n++) begin
            for (int k = 0; k < NumAlt; k++) begin
                if (sel_q[n] == 4'(k + 1)) begin
                    c2p[n]                = alt_o_i[k*NumPads + n];
                    c2p_en[n]             = alt_oe_i[k*NumPads + n];
                    alt_in[k*NumPads + n] = cond[n];
                end
            end
            if (force_in_q[n]) begin
                c2p_en[n] = 1'b0;
            end
        end
    end

    assign pad_c2p_o    = c2p;
    assign pad_c2p_en_o = c2p_en;
    assign gpio_i_o     = cond;
    assign alt_i_o      = alt_in;

endmodule

// File: tb/tb_croc_pad_mux.sv
// Bench for croc_pad_mux: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_croc_pad_mux;
    localparam int NP = 32;
    localparam int NA = 2;
    localparam int DW = 8;
    localparam int DD = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             reg_req_i, reg_we_i;
    logic [7:0]       reg_addr_i;
    logic [31:0]      reg_wdata_i;
    logic             reg_gnt_o, reg_rvalid_o, reg_err_o;
    logic [31:0]      reg_rdata_o;
    logic [NP-1:0]    gpio_o_i, gpio_oe_i, gpio_i_o;
    logic [NA*NP-1:0] alt_o_i, alt_oe_i, alt_i_o;
    logic [NP-1:0]    pad_c2p_o, pad_c2p_en_o, pad_p2c_i;

    always #5 clk_i = ~clk_i;

    croc_pad_mux #(
        .NumPads(NP), .NumAlt(NA), .DebounceW(DW), .DebounceDefault(DD), .AltInIdle(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
        .reg_wdata_i(reg_wdata_i), .reg_gnt_o(reg_gnt_o), .reg_rvalid_o(reg_rvalid_o),
        .reg_rdata_o(reg_rdata_o), .reg_err_o(reg_err_o),
        .gpio_o_i(gpio_o_i), .gpio_oe_i(gpio_oe_i), .gpio_i_o(gpio_i_o),
        .alt_o_i(alt_o_i), .alt_oe_i(alt_oe_i), .alt_i_o(alt_i_o),
        .pad_c2p_o(pad_c2p_o), .pad_c2p_en_o(pad_c2p_en_o), .pad_p2c_i(pad_p2c_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [3:0]    m_sel [NP];
    logic [NP-1:0] m_deb, m_frc, m_s1, m_s2, m_filt;
    int            m_run [NP];
    int            m_thr;
    logic          m_rv, m_err;
    logic [31:0]   m_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_c(input int n);
        return (m_deb[n] && m_thr != 0) ? m_filt[n] : m_s2[n];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NP; n++) begin
            m_sel[n] = '0;
            m_run[n] = 0;
        end
        m_deb = '0; m_frc = '0; m_s1 = '0; m_s2 = '0; m_filt = '0;
        m_thr = DD; m_rv = 1'b0; m_err = 1'b0; m_rd = '0;
    endtask

    task automatic check_all();
        logic [NP-1:0]    e_c2p, e_en, e_gi;
        logic [NA*NP-1:0] e_ai;
        int s;
        for (int n = 0; n < NP; n++) begin
            s = int'(m_sel[n]);
            e_gi[n]  = m_c(n);
            e_c2p[n] = (s == 0) ? gpio_o_i[n]  : alt_o_i[(s-1)*NP + n];
            e_en[n]  = (s == 0) ? gpio_oe_i[n] : alt_oe_i[(s-1)*NP + n];
            if (m_frc[n]) e_en[n] = 1'b0;
            for (int k = 0; k < NA; k++) begin
                e_ai[k*NP + n] = (s == k + 1) ? m_c(n) : 1'b1;
            end
        end
        chk("gnt", 64'(reg_gnt_o), 64'(reg_req_i));
        chk("rvalid", 64'(reg_rvalid_o), 64'(m_rv));
        if (m_rv) begin
            chk("rdata", 64'(reg_rdata_o), 64'(m_rd));
            chk("err", 64'(reg_err_o), 64'(m_err));
        end
        chk("c2p", 64'(pad_c2p_o), 64'(e_c2p));
        chk("c2p_en", 64'(pad_c2p_en_o), 64'(e_en));
        chk("gpio_i", 64'(gpio_i_o), 64'(e_gi));
        chk("alt_i", 64'(alt_i_o), 64'(e_ai));
    endtask

    // One clock: decode the request from pre-edge model state, advance the model, then compare.
    task automatic step();
        logic [31:0] rd;
        logic        er, wr_ok;
        int          a;
        rd = '0; er = 1'b0; wr_ok = 1'b0; a = int'(reg_addr_i);
        if (reg_req_i) begin
            if (a < NP) begin
                if (reg_we_i) begin
                    if (int'(reg_wdata_i[3:0]) > NA) er = 1'b1;
                    else wr_ok = 1'b1;
                end else begin
                    rd = {26'd0, m_frc[a], m_deb[a], m_sel[a]};
                end
            end else if (a == NP) begin
                if (reg_we_i) wr_ok = 1'b1;
                else rd = 32'(m_thr);
            end else if (a == NP + 1) begin
                if (reg_we_i) er = 1'b1;
                else rd = 32'(m_s2);
            end else begin
                er = 1'b1;
            end
        end
        @(posedge clk_i);
        if (rst_i) begin
            model_reset();
        end else begin
            for (int n = 0; n < NP; n++) begin
                if (!(m_deb[n] && m_thr != 0)) begin
                    m_filt[n] = m_s2[n];
                    m_run[n]  = 0;
                end else if (m_s2[n] == m_filt[n]) begin
                    m_run[n] = 0;
                end else begin
                    m_run[n]++;
                    if (m_run[n] >= m_thr) begin
                        m_filt[n] = m_s2[n];
                        m_run[n]  = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = pad_p2c_i;
            if (wr_ok) begin
                if (a < NP) begin
                    m_sel[a] = reg_wdata_i[3:0];
                    m_deb[a] = reg_wdata_i[4];
                    m_frc[a] = reg_wdata_i[5];
                end else begin
                    m_thr = int'(reg_wdata_i[DW-1:0]);
                end
            end
            m_rv = reg_req_i; m_rd = rd; m_err = er;
        end
        #1;
        check_all();
    endtask

    task automatic req_on(input logic we, input int addr, input logic [31:0] wd);
        reg_req_i = 1'b1; reg_we_i = we; reg_addr_i = 8'(addr); reg_wdata_i = wd;
    endtask

    task automatic req_off();
        reg_req_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
    endtask

    task automatic access(input logic we, input int addr, input logic [31:0] wd);
        req_on(we, addr, wd);
        step();
        req_off();
    endtask

    initial begin
        logic        saw_high;
        int          rise_at;
        logic [31:0] wd;
        int          r, a;

        rst_i = 1'b1;
        req_off();
        gpio_o_i = '0; gpio_oe_i = '0; alt_o_i = '0; alt_oe_i = '0; pad_p2c_i = '0;
        model_reset();
        step(); step();
        rst_i = 1'b0;

        // Reset values and default GPIO routing
        access(1'b0, 3, 32'h0);
        chk("rst_padcfg3", 64'(reg_rdata_o), 64'd0);
        access(1'b0, NP, 32'h0);
        chk("rst_debthr", 64'(reg_rdata_o), 64'd16);
        gpio_oe_i = $urandom; gpio_o_i = $urandom;
        step();
        chk("rst_en_is_gpio_oe", 64'(pad_c2p_en_o), 64'(gpio_oe_i));

        // Alt function 0 on pad 5, then force_in
        access(1'b1, 5, 32'h1);
        gpio_o_i[5] = 1'b0; gpio_oe_i[5] = 1'b0;
        alt_o_i[5] = 1'b1; alt_oe_i[5] = 1'b1;
        step();
        chk("alt0_c2p5", 64'(pad_c2p_o[5]), 64'd1);
        chk("alt0_en5", 64'(pad_c2p_en_o[5]), 64'd1);
        chk("alt1_idle5", 64'(alt_i_o[NP + 5]), 64'd1);
        access(1'b1, 5, 32'h21);
        chk("force_in_en5", 64'(pad_c2p_en_o[5]), 64'd0);
        chk("force_in_c2p5", 64'(pad_c2p_o[5]), 64'd1);

        // Debounce on pad 2 with threshold 4
        access(1'b1, 2, 32'h10);
        access(1'b1, NP, 32'h4);
        repeat (4) step();
        pad_p2c_i[2] = 1'b1;
        repeat (3) step();
        pad_p2c_i[2] = 1'b0;
        saw_high = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (gpio_i_o[2]) saw_high = 1'b1;
        end
        chk("deb_reject_short", 64'(saw_high), 64'd0);
        pad_p2c_i[2] = 1'b1;
        rise_at = -1;
        for (int i = 1; i <= 20 && rise_at < 0; i++) begin
            step();
            if (gpio_i_o[2]) rise_at = i;
        end
        chk("deb_rise_cycle", 64'(rise_at), 64'd6);
        pad_p2c_i[2] = 1'b0;
        repeat (8) step();

        // Error responses leave state untouched
        access(1'b1, 0, 32'h3);
        chk("err_sel_range", 64'(reg_err_o), 64'd1);
        chk("err_sel_rdata", 64'(reg_rdata_o), 64'd0);
        access(1'b0, 0, 32'h0);
        chk("err_padcfg0_kept", 64'(reg_rdata_o), 64'd0);
        access(1'b0, 8'h80, 32'h0);
        chk("err_bad_addr", 64'(reg_err_o), 64'd1);
        access(1'b1, NP + 1, 32'hFFFF_FFFF);
        chk("err_status_wr", 64'(reg_err_o), 64'd1);
        access(1'b0, NP, 32'h0);
        chk("err_debthr_kept", 64'(reg_rdata_o), 64'd4);

        // Reset during a read drops the response
        req_on(1'b0, NP, 32'h0);
        rst_i = 1'b1;
        step();
        chk("rst_drop_rvalid", 64'(reg_rvalid_o), 64'd0);
        rst_i = 1'b0;
        req_off();
        step();
        access(1'b0, NP, 32'h0);
        chk("rst2_debthr", 64'(reg_rdata_o), 64'd16);
        access(1'b0, 5, 32'h0);
        chk("rst2_padcfg5", 64'(reg_rdata_o), 64'd0);

        // Back-to-back writes then reads, request held every cycle
        for (int n = 0; n < 8; n++) begin
            req_on(1'b1, n, 32'hABCD_0000 | 32'(n % 3) | 32'((n & 1) << 4) | 32'(((n >> 2) & 1) << 5));
            step();
        end
        for (int n = 0; n < 8; n++) begin
            req_on(1'b0, n, 32'h0);
            step();
            chk("b2b_rvalid", 64'(reg_rvalid_o), 64'd1);
            chk("b2b_rdata", 64'(reg_rdata_o), 64'((n % 3) | ((n & 1) << 4) | (((n >> 2) & 1) << 5)));
        end
        req_off();
        step();

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_i = ($urandom_range(0, 499) == 0);
            gpio_o_i = $urandom; gpio_oe_i = $urandom;
            alt_o_i = {$urandom, $urandom}; alt_oe_i = {$urandom, $urandom};
            pad_p2c_i = pad_p2c_i ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 9);
                if (r <= 6) a = $urandom_range(0, NP - 1);
                else if (r == 7) a = NP;
                else if (r == 8) a = NP + 1;
                else a = $urandom_range(0, 255);
                wd = $urandom & 32'hFFFF_FFC0;
                if (a == NP) wd = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 6));
                else if ($urandom_range(0, 7) == 0) wd = wd | 32'($urandom_range(0, 63));
                else wd = wd | 32'($urandom_range(0, 3)) | 32'($urandom_range(0, 3) << 4);
                req_on(1'($urandom_range(0, 1)), a, wd);
            end else begin
                req_off();
            end
            step();
        end
        rst_i = 1'b0;
        req_off();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
